lfsr_sym_checker: RTL and testbench

//  Receive-end counterpart of the LFSR symbol source. Takes sliced 4-bit 16-QAM RX symbols and the

---
 rtl/lfsr_sym_checker.sv | 172 +++++++++++++++++
 tb/tb_lfsr_sym_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_sym_checker.sv
// Aligns sliced RX symbols to the LFSR TX stream by delay sweep, then counts symbol/bit errors per window.
// Counts and meas_valid are registered (1 sys_clk after the completing enable); no backpressure, advances only on sym_clk_en.
module lfsr_sym_checker #(
    parameter int MAX_DELAY   = 32,
    parameter int SEARCH_LEN  = 64,
    parameter int LOCK_THRESH = 2,
    parameter int WINDOW_LEN  = 1024,
    parameter int LOSS_THRESH = 64,
    parameter int CNT_W       = 24
) (
    input  logic                         sys_clk,
    input  logic                         reset,
    input  logic                         sym_clk_en,
    input  logic [3:0]                   tx_sym,
    input  logic [3:0]                   rx_sym,
    output logic                         locked,
    output logic [$clog2(MAX_DELAY)-1:0] delay_sel,
    output logic [CNT_W-1:0]             sym_err_cnt,
    output logic [CNT_W-1:0]             bit_err_cnt,
    output logic                         meas_valid
);

    localparam int DW   = $clog2(MAX_DELAY);
    localparam int CMAX = (SEARCH_LEN > WINDOW_LEN) ? SEARCH_LEN : WINDOW_LEN;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CNT_W-1:0] SAT = '1;

    typedef enum logic [1:0] {ST_FLUSH, ST_SEARCH, ST_LOCKED} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     delay_sel_q, delay_sel_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     srch_acc_q, srch_acc_d;
    logic [CNT_W-1:0]  sym_acc_q, sym_acc_d;
    logic [CNT_W-1:0]  bit_acc_q, bit_acc_d;
    logic [CNT_W-1:0]  sym_err_q, sym_err_d;
    logic [CNT_W-1:0]  bit_err_q, bit_err_d;
    logic              meas_valid_q, meas_valid_d;

    logic [3:0]        tap_q [1:MAX_DELAY-1];
    logic [3:0]        taps  [0:MAX_DELAY-1];
    logic [3:0]        ref_sym;
    logic [3:0]        diff;
    logic              mism;
    logic [2:0]        nbits;
    logic [CNT_W:0]    sym_wide;
    logic [CNT_W:0]    bit_wide;
    logic [CNT_W-1:0]  sym_sum;
    logic [CNT_W-1:0]  bit_sum;
    logic [CW-1:0]     srch_sum;

    // Tap 0 is the live TX symbol; the line is never reset, FLUSH refills it.
    always_comb begin
        taps[0] = tx_sym;
        for (int k = 1; k < MAX_DELAY; k++) begin
            taps[k] = tap_q[k];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sym_clk_en) begin
            for (int k = 1; k < MAX_DELAY; k++) begin
                tap_q[k] <= taps[k-1];
            end
        end
    end

    always_comb begin
        ref_sym  = taps[delay_sel_q];
        diff     = rx_sym ^ ref_sym;
        mism     = |diff;
        nbits    = 3'(diff[0]) + 3'(diff[1]) + 3'(diff[2]) + 3'(diff[3]);
        sym_wide = {1'b0, sym_acc_q} + (CNT_W+1)'(mism);
        bit_wide = {1'b0, bit_acc_q} + (CNT_W+1)'(nbits);
        sym_sum  = sym_wide[CNT_W] ? SAT : sym_wide[CNT_W-1:0];
        bit_sum  = bit_wide[CNT_W] ? SAT : bit_wide[CNT_W-1:0];
        srch_sum = srch_acc_q + CW'(mism);
    end

    always_comb begin
        state_d      = state_q;
        delay_sel_d  = delay_sel_q;
        cnt_d        = cnt_q;
        srch_acc_d   = srch_acc_q;
        sym_acc_d    = sym_acc_q;
        bit_acc_d    = bit_acc_q;
        sym_err_d    = sym_err_q;
        bit_err_d    = bit_err_q;
        meas_valid_d = 1'b0;
        if (sym_clk_en) begin
            case (state_q)
                ST_FLUSH: begin
                    if (int'(cnt_q) == MAX_DELAY - 1) begin
                        state_d    = ST_SEARCH;
                        cnt_d      = '0;
                        srch_acc_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SEARCH: begin
                    if (int'(cnt_q) == SEARCH_LEN - 1) begin
                        cnt_d      = '0;
                        srch_acc_d = '0;
                        sym_acc_d  = '0;
                        bit_acc_d  = '0;
                        if (int'(srch_sum) <= LOCK_THRESH) begin
                            state_d = ST_LOCKED;
                        end else begin
                            delay_sel_d = delay_sel_q + DW'(1);
                        end
                    end else begin
                        cnt_d      = cnt_q + CW'(1);
                        srch_acc_d = srch_sum;
                    end
                end
                ST_LOCKED: begin
                    if (int'(cnt_q) == WINDOW_LEN - 1) begin
                        cnt_d        = '0;
                        sym_acc_d    = '0;
                        bit_acc_d    = '0;
                        sym_err_d    = sym_sum;
                        bit_err_d    = bit_sum;
                        meas_valid_d = 1'b1;
                        // A failed window is still published before re-searching.
                        if (int'(sym_sum) > LOSS_THRESH) begin
                            state_d     = ST_SEARCH;
                            srch_acc_d  = '0;
                            delay_sel_d = delay_sel_q + DW'(1);
                        end
                    end else begin
                        cnt_d     = cnt_q + CW'(1);
                        sym_acc_d = sym_sum;
                        bit_acc_d = bit_sum;
                    end
                end
                default: state_d = ST_FLUSH;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= ST_FLUSH;
            delay_sel_q  <= '0;
            cnt_q        <= '0;
            srch_acc_q   <= '0;
            sym_acc_q    <= '0;
            bit_acc_q    <= '0;
            sym_err_q    <= '0;
            bit_err_q    <= '0;
            meas_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            delay_sel_q  <= delay_sel_d;
            cnt_q        <= cnt_d;
            srch_acc_q   <= srch_acc_d;
            sym_acc_q    <= sym_acc_d;
            bit_acc_q    <= bit_acc_d;
            sym_err_q    <= sym_err_d;
            bit_err_q    <= bit_err_d;
            meas_valid_q <= meas_valid_d;
        end
    end

    assign locked      = (state_q == ST_LOCKED);
    assign delay_sel   = delay_sel_q;
    assign sym_err_cnt = sym_err_q;
    assign bit_err_cnt = bit_err_q;
    assign meas_valid  = meas_valid_q;

endmodule

// File: tb/tb_lfsr_sym_checker.sv
// Bench for lfsr_sym_checker: random TX symbols, RX built as delayed/corrupted TX,
// outputs checked every cycle against an enable-indexed reference model.
module tb_lfsr_sym_checker;

    logic        sys_clk;
    logic        rst0, rst1;
    logic        en_i;
    logic [3:0]  tx_sym, rx0, rx1;
    logic        locked0, locked1, mv0, mv1;
    logic [4:0]  delay0, delay1;
    logic [23:0] sym0, bit0;
    logic [7:0]  sym1, bit1;
    logic [54:0] obs0, obs1;

    lfsr_sym_checker dut0 (
        .sys_clk(sys_clk), .reset(rst0), .sym_clk_en(en_i), .tx_sym(tx_sym), .rx_sym(rx0),
        .locked(locked0), .delay_sel(delay0), .sym_err_cnt(sym0), .bit_err_cnt(bit0),
        .meas_valid(mv0));

    lfsr_sym_checker #(.CNT_W(8), .WINDOW_LEN(128)) dut1 (
        .sys_clk(sys_clk), .reset(rst1), .sym_clk_en(en_i), .tx_sym(tx_sym), .rx_sym(rx1),
        .locked(locked1), .delay_sel(delay1), .sym_err_cnt(sym1), .bit_err_cnt(bit1),
        .meas_valid(mv1));

    assign obs0 = {locked0, delay0, mv0, sym0, bit0};
    assign obs1 = {locked1, delay1, mv1, 16'd0, sym1, 16'd0, bit1};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: phase 0 flush, 1 search, 2 locked; counts are enables seen so far.
    logic [3:0] txlog[$];
    int rx_d0 = 0, rx_d1 = 0;
    bit rx1_inv = 0;
    int WIN[2]  = '{1024, 128};
    int SATV[2] = '{16777215, 255};
    int m_phase[2], m_cnt[2], m_acc[2], m_sym[2], m_bit[2], m_delay[2], m_symo[2], m_bito[2];
    bit m_mv[2];

    task automatic model_step(input int i, input bit rst, input bit en, input logic [3:0] rx);
        logic [3:0] r;
        int nb;
        m_mv[i] = 1'b0;
        if (rst) begin
            m_phase[i] = 0; m_cnt[i] = 0; m_acc[i] = 0; m_sym[i] = 0; m_bit[i] = 0;
            m_delay[i] = 0; m_symo[i] = 0; m_bito[i] = 0;
            return;
        end
        if (!en) return;
        r  = txlog[txlog.size() - 1 - m_delay[i]];
        nb = $countones(rx ^ r);
        m_cnt[i]++;
        if (m_phase[i] == 0) begin
            if (m_cnt[i] == 32) begin m_phase[i] = 1; m_cnt[i] = 0; m_acc[i] = 0; end
        end else if (m_phase[i] == 1) begin
            m_acc[i] += (nb != 0) ? 1 : 0;
            if (m_cnt[i] == 64) begin
                if (m_acc[i] <= 2) m_phase[i] = 2;
                else m_delay[i] = (m_delay[i] + 1) % 32;
                m_cnt[i] = 0; m_acc[i] = 0; m_sym[i] = 0; m_bit[i] = 0;
            end
        end else begin
            m_sym[i] = (m_sym[i] + ((nb != 0) ? 1 : 0) > SATV[i]) ? SATV[i] : m_sym[i] + ((nb != 0) ? 1 : 0);
            m_bit[i] = (m_bit[i] + nb > SATV[i]) ? SATV[i] : m_bit[i] + nb;
            if (m_cnt[i] == WIN[i]) begin
                m_symo[i] = m_sym[i]; m_bito[i] = m_bit[i]; m_mv[i] = 1'b1;
                if (m_sym[i] > 64) begin m_phase[i] = 1; m_delay[i] = (m_delay[i] + 1) % 32; end
                m_cnt[i] = 0; m_sym[i] = 0; m_bit[i] = 0; m_acc[i] = 0;
            end
        end
    endtask

    function automatic logic [54:0] exp_pack(input int i);
        return {(m_phase[i] == 2), 5'(m_delay[i]), m_mv[i], 24'(m_symo[i]), 24'(m_bito[i])};
    endfunction

    task automatic tick(input bit en, input logic [3:0] err0);
        logic [3:0] tx;
        tx = 4'($urandom);
        if (en) txlog.push_back(tx);
        tx_sym = tx;
        en_i   = en;
        rx0    = txlog[txlog.size() - 1 - rx_d0] ^ err0;
        rx1    = txlog[txlog.size() - 1 - rx_d1] ^ (rx1_inv ? 4'hF : 4'h0);
        model_step(0, rst0, en, rx0);
        model_step(1, rst1, en, rx1);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        tick(1, 4'h0);
        tick(1, 4'h0);
        n_cmp++;
        if (obs0 !== 55'd0) begin n_fail++; $display("FAIL reset_state: got %h want 0", obs0); end
        n_cmp++;
        if (obs0 !== exp_pack(0)) begin n_fail++; $display("FAIL reset_model: got %h want %h", obs0, exp_pack(0)); end
        rst0 = 1'b0;
    endtask

    task automatic test_acquire();
        rx_d0 = 7;
        for (int n = 1; n <= 744; n++) begin
            tick(1, 4'h0);
            n_cmp++;
            if (obs0 !== exp_pack(0)) begin n_fail++; $display("FAIL acquire n=%0d: got %h want %h", n, obs0, exp_pack(0)); end
            if (n == 543) begin
                n_cmp++;
                if (locked0 !== 1'b0) begin n_fail++; $display("FAIL acquire_early: locked=%b want 0", locked0); end
            end
            if (n == 544 || n == 744) begin
                n_cmp++;
                if (locked0 !== 1'b1 || delay0 !== 5'd7) begin
                    n_fail++; $display("FAIL acquire_lock n=%0d: locked=%b delay=%0d want 1/7", n, locked0, delay0);
                end
            end
        end
    endtask

    task automatic test_window_errors();
        int pulses = 0;
        int r = $urandom_range(300, 1000);
        for (int n = 0; n < 2600 && pulses < 2; n++) begin
            tick(1, (m_cnt[0] == r) ? 4'b0101 : 4'b0000);
            n_cmp++;
            if (obs0 !== exp_pack(0)) begin n_fail++; $display("FAIL window: got %h want %h", obs0, exp_pack(0)); end
            if (mv0) begin
                pulses++;
                n_cmp++;
                if (sym0 !== 24'd1 || bit0 !== 24'd2) begin
                    n_fail++; $display("FAIL window_counts: sym=%0d bit=%0d want 1/2", sym0, bit0);
                end
            end
        end
        n_cmp++;
        if (pulses != 2) begin n_fail++; $display("FAIL window_pulses: got %0d want 2", pulses); end
    endtask

    task automatic test_stall();
        logic [54:0] snap;
        int k = 0;
        for (int n = 0; n < 1100 && m_cnt[0] != 500; n++) tick(1, 4'h0);
        snap = obs0;
        for (int n = 0; n < 500; n++) begin
            tick(0, 4'h0);
            n_cmp++;
            if (obs0 !== snap || obs0 !== exp_pack(0)) begin
                n_fail++; $display("FAIL stall: got %h want %h", obs0, snap);
            end
        end
        for (int n = 1; n <= 700; n++) begin
            tick(1, 4'h0);
            n_cmp++;
            if (obs0 !== exp_pack(0)) begin n_fail++; $display("FAIL stall_resume: got %h want %h", obs0, exp_pack(0)); end
            if (mv0) begin k = n; break; end
        end
        n_cmp++;
        if (k != 524 || sym0 !== 24'd0 || bit0 !== 24'd0 || locked0 !== 1'b1) begin
            n_fail++; $display("FAIL stall_window: enables=%0d sym=%0d bit=%0d want 524/0/0", k, sym0, bit0);
        end
    endtask

    task automatic test_loss();
        int k = 0;
        rx_d0 = 9;
        for (int n = 1; n <= 1100; n++) begin
            tick(1, 4'h0);
            n_cmp++;
            if (obs0 !== exp_pack(0)) begin n_fail++; $display("FAIL loss: got %h want %h", obs0, exp_pack(0)); end
            if (mv0) begin k = n; break; end
        end
        n_cmp++;
        if (k != 1024 || !(sym0 > 24'd64) || locked0 !== 1'b0 || delay0 !== 5'd8) begin
            n_fail++; $display("FAIL loss_drop: enables=%0d sym=%0d locked=%b delay=%0d want 1024/>64/0/8",
                               k, sym0, locked0, delay0);
        end
        for (int n = 1; n <= 128; n++) begin
            tick(1, 4'h0);
            n_cmp++;
            if (obs0 !== exp_pack(0)) begin n_fail++; $display("FAIL relock: got %h want %h", obs0, exp_pack(0)); end
            if (n == 64 || n == 128) begin
                n_cmp++;
                if (locked0 !== (n == 128) || delay0 !== 5'd9) begin
                    n_fail++; $display("FAIL relock_state n=%0d: locked=%b delay=%0d want %0d/9", n, locked0, delay0, n == 128);
                end
            end
        end
    endtask

    task automatic test_reset_relock();
        rst0 = 1'b1; rx_d0 = 7;
        tick(1, 4'h0);
        rst0 = 1'b0;
        n_cmp++;
        if (obs0 !== 55'd0) begin n_fail++; $display("FAIL rst_locked: got %h want 0", obs0); end
        for (int n = 1; n <= 544; n++) begin
            tick(1, 4'h0);
            n_cmp++;
            if (obs0 !== exp_pack(0)) begin n_fail++; $display("FAIL rst_relock: got %h want %h", obs0, exp_pack(0)); end
        end
        n_cmp++;
        if (locked0 !== 1'b1 || delay0 !== 5'd7) begin
            n_fail++; $display("FAIL rst_relock_lock: locked=%b delay=%0d want 1/7", locked0, delay0);
        end
    endtask

    task automatic test_saturation();
        int k = 0;
        rst1 = 1'b0; rx_d1 = 3; rx1_inv = 1'b0;
        for (int n = 1; n <= 288; n++) begin
            tick(1, 4'h0);
            n_cmp++;
            if (obs1 !== exp_pack(1)) begin n_fail++; $display("FAIL sat_acquire: got %h want %h", obs1, exp_pack(1)); end
        end
        n_cmp++;
        if (locked1 !== 1'b1 || delay1 !== 5'd3) begin
            n_fail++; $display("FAIL sat_lock: locked=%b delay=%0d want 1/3", locked1, delay1);
        end
        rx1_inv = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            tick(1, 4'h0);
            n_cmp++;
            if (obs1 !== exp_pack(1)) begin n_fail++; $display("FAIL sat_window: got %h want %h", obs1, exp_pack(1)); end
            if (mv1) begin k = n; break; end
        end
        n_cmp++;
        if (k != 128 || sym1 !== 8'd128 || bit1 !== 8'd255 || locked1 !== 1'b0 || delay1 !== 5'd4) begin
            n_fail++; $display("FAIL sat_counts: enables=%0d sym=%0d bit=%0d locked=%b delay=%0d want 128/128/255/0/4",
                               k, sym1, bit1, locked1, delay1);
        end
        for (int n = 1; n <= 1792; n++) begin
            tick(1, 4'h0);
            n_cmp++;
            if (obs1 !== exp_pack(1)) begin n_fail++; $display("FAIL sat_sweep: got %h want %h", obs1, exp_pack(1)); end
            if (n == 1791 || n == 1792) begin
                n_cmp++;
                if (locked1 !== 1'b0 || delay1 !== ((n == 1791) ? 5'd31 : 5'd0)) begin
                    n_fail++; $display("FAIL sat_wrap n=%0d: locked=%b delay=%0d", n, locked1, delay1);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 40; i++) txlog.push_back(4'($urandom));
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_cnt[i] = 0; m_acc[i] = 0; m_sym[i] = 0; m_bit[i] = 0;
            m_delay[i] = 0; m_symo[i] = 0; m_bito[i] = 0; m_mv[i] = 1'b0;
        end
        rst0 = 1'b1; rst1 = 1'b1; en_i = 1'b0;
        tx_sym = 4'h0; rx0 = 4'h0; rx1 = 4'h0;
        test_reset();
        test_acquire();
        test_window_errors();
        test_stall();
        test_loss();
        test_reset_relock();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
